sfif_tx_fifo: RTL and testbench

- Store-and-forward transmit buffer for the 64-bit PCIe TX TLP interface. It is the transmit counterpart of the SFIF RX capture FIFO.
- A local 32-bit producer writes TLPs one DW at a time, marking the last DW of each TLP.
- The block packs DW pairs into 64-bit entries and holds each TLP until it is complete. It then requests the core and streams the TLP with tx_st / tx_end / tx_dwen framing.
- Single clock domain: clk_125.

---
 rtl/sfif_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_sfif_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfif_tx_fifo.sv
// Store-and-forward TX buffer: packs 32-bit producer DWs into 64-bit entries and
// releases each TLP to the 64-bit core interface only once it is completely stored.
module sfif_tx_fifo #(
  parameter int AW = 9
) (
  input  logic          clk_125,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          wr_last,
  output logic          full,
  output logic          ovf,
  output logic [AW:0]   pkt_cnt,
  output logic          tx_req,
  input  logic          tx_rdy,
  input  logic          tx_val,
  output logic          tx_st,
  output logic          tx_end,
  output logic          tx_dwen,
  output logic [63:0]   tx_data,
  output logic          busy
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_REQ   = 2'd1;
  localparam logic [1:0]  ST_SEND  = 2'd2;
  localparam logic [AW:0] DEPTH    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ZERO_CNT = {(AW+1){1'b0}};

  logic [65:0]   mem_r [2**AW];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   ent_cnt_r;
  logic [AW:0]   pkt_cnt_r;
  logic [31:0]   hold_r;
  logic          hold_valid_r;
  logic          ovf_r;
  logic          tx_req_r;
  logic          first_r;
  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;

  logic          full_s;
  logic          need_ent_s;
  logic          ent_wr_s;
  logic          drop_s;
  logic          cap_s;
  logic          pkt_inc_s;
  logic          beat_s;
  logic          pkt_dec_s;
  logic [65:0]   ent_s;
  logic [65:0]   cur_s;
  logic [AW:0]   pkt_nxt_s;

  // Write packing, overflow decision and beat acceptance; full is taken before acceptance
  always_comb begin
    full_s     = (ent_cnt_r == DEPTH);
    need_ent_s = wr_en && (hold_valid_r || wr_last);
    ent_wr_s   = need_ent_s && !full_s;
    drop_s     = need_ent_s && full_s;
    cap_s      = wr_en && !wr_last && !hold_valid_r;
    pkt_inc_s  = ent_wr_s && wr_last;
    cur_s      = mem_r[rd_ptr_r];
    beat_s     = (state_r == ST_SEND) && tx_val;
    pkt_dec_s  = beat_s && cur_s[65];
    pkt_nxt_s  = pkt_cnt_r + {{AW{1'b0}}, pkt_inc_s} - {{AW{1'b0}}, pkt_dec_s};
    if (hold_valid_r) begin
      ent_s = {wr_last, 1'b0, hold_r, wr_data};
    end else begin
      ent_s = {1'b1, 1'b1, wr_data, 32'd0};
    end
  end

  // Request/send sequencing; a finishing TLP goes straight back to REQ if more are queued
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pkt_cnt_r != ZERO_CNT) state_nxt_s = ST_REQ;
        else                       state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (tx_rdy) state_nxt_s = ST_SEND;
        else        state_nxt_s = ST_REQ;
      end
      ST_SEND: begin
        if (pkt_dec_s) begin
          if (pkt_nxt_s == ZERO_CNT) state_nxt_s = ST_IDLE;
          else                       state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pointers, counters, holding register, sticky overflow and FSM state
  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      tx_req_r     <= 1'b0;
      first_r      <= 1'b0;
      pkt_cnt_r    <= ZERO_CNT;
      ent_cnt_r    <= ZERO_CNT;
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      hold_r       <= 32'd0;
      hold_valid_r <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      tx_req_r  <= (state_nxt_s == ST_REQ);
      pkt_cnt_r <= pkt_nxt_s;
      ent_cnt_r <= ent_cnt_r + {{AW{1'b0}}, ent_wr_s} - {{AW{1'b0}}, beat_s};
      if (ent_wr_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (beat_s)   rd_ptr_r <= rd_ptr_r + 1'b1;
      if (drop_s)   ovf_r    <= 1'b1;
      if (cap_s) begin
        hold_r       <= wr_data;
        hold_valid_r <= 1'b1;
      end else if (ent_wr_s) begin
        hold_valid_r <= 1'b0;
      end
      if ((state_r == ST_REQ) && tx_rdy) first_r <= 1'b1;
      else if (beat_s)                   first_r <= 1'b0;
    end
  end

  // Entry storage; contents need no reset
  always_ff @(posedge clk_125) begin
    if (ent_wr_s) mem_r[wr_ptr_r] <= ent_s;
  end

  // Output drive: beat fields come straight from the head entry while sending
  always_comb begin
    full    = full_s;
    ovf     = ovf_r;
    pkt_cnt = pkt_cnt_r;
    tx_req  = tx_req_r;
    busy    = (state_r != ST_IDLE);
    if (state_r == ST_SEND) begin
      tx_data = cur_s[63:0];
      tx_end  = cur_s[65];
      tx_dwen = cur_s[65] & cur_s[64];
      tx_st   = first_r;
    end else begin
      tx_data = 64'd0;
      tx_end  = 1'b0;
      tx_dwen = 1'b0;
      tx_st   = 1'b0;
    end
  end

endmodule

// File: tb/tb_sfif_tx_fifo.sv
// Bench for sfif_tx_fifo: directed scenarios plus randomized traffic checked
// against a queue-based model of stored TLPs.
module tb_sfif_tx_fifo;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic        clk_125 = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_last;
  logic        full;
  logic        ovf;
  logic [AW:0] pkt_cnt;
  logic        tx_req;
  logic        tx_rdy;
  logic        tx_val;
  logic        tx_st;
  logic        tx_end;
  logic        tx_dwen;
  logic [63:0] tx_data;
  logic        busy;

  always #4 clk_125 = ~clk_125;

  sfif_tx_fifo #(.AW(AW)) dut (
    .clk_125 (clk_125), .rstn (rstn), .wr_en (wr_en), .wr_data (wr_data),
    .wr_last (wr_last), .full (full), .ovf (ovf), .pkt_cnt (pkt_cnt),
    .tx_req (tx_req), .tx_rdy (tx_rdy), .tx_val (tx_val), .tx_st (tx_st),
    .tx_end (tx_end), .tx_dwen (tx_dwen), .tx_data (tx_data), .busy (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: completed TLPs as a DW stream plus their lengths
  logic [31:0] q_dw[$];
  int          q_len[$];
  logic [31:0] cur_wr[$];
  int          m_ent, m_pkt, m_beat;
  bit          m_hold, m_ovf, m_send;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    q_dw.delete(); q_len.delete(); cur_wr.delete();
    m_ent = 0; m_pkt = 0; m_beat = 0;
    m_hold = 1'b0; m_ovf = 1'b0; m_send = 1'b0;
  endtask

  // Check outputs at the falling edge, advance the model by one cycle, move to next falling edge
  task automatic tick();
    int len, nb;
    logic [31:0] e0, e1;
    bit need;
    len = 0; nb = 0;
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    chk("full", 64'(full), 64'(m_ent == DEPTH));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    if (m_send) begin
      len = q_len[0];
      nb  = (len + 1) / 2;
      e0  = q_dw[2*m_beat];
      e1  = (2*m_beat + 1 < len) ? q_dw[2*m_beat+1] : 32'd0;
      chk("tx_data", tx_data, {e0, e1});
      chk("tx_st", 64'(tx_st), 64'(m_beat == 0));
      chk("tx_end", 64'(tx_end), 64'(m_beat == nb - 1));
      chk("tx_dwen", 64'(tx_dwen), 64'((m_beat == nb - 1) && (len % 2 == 1)));
      chk("busy_send", 64'(busy), 64'(1));
      chk("req_in_send", 64'(tx_req), 64'(0));
    end else begin
      chk("idle_outs", tx_data | 64'({tx_st, tx_end, tx_dwen}), 64'(0));
      chk("req_spur", 64'(tx_req && (m_pkt == 0)), 64'(0));
    end
    need = wr_en && (m_hold || wr_last);
    if (wr_en) begin
      if (need && (m_ent == DEPTH)) begin
        m_ovf = 1'b1;
      end else begin
        cur_wr.push_back(wr_data);
        if (need) begin m_ent++; m_hold = 1'b0; end
        else m_hold = 1'b1;
        if (wr_last) begin
          foreach (cur_wr[i]) q_dw.push_back(cur_wr[i]);
          q_len.push_back(cur_wr.size());
          cur_wr.delete();
          m_pkt++;
        end
      end
    end
    if (m_send && tx_val) begin
      m_ent--;
      m_beat++;
      if (m_beat == nb) begin
        for (int i = 0; i < len; i++) void'(q_dw.pop_front());
        void'(q_len.pop_front());
        m_pkt--;
        m_send = 1'b0;
        m_beat = 0;
      end
    end
    if (tx_rdy) begin
      chk("req_at_grant", 64'(tx_req), 64'(1));
      if (!m_send && (q_len.size() > 0)) begin m_send = 1'b1; m_beat = 0; end
    end
    @(negedge clk_125);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    wr_en = 1'b0; wr_data = 32'd0; wr_last = 1'b0; tx_rdy = 1'b0; tx_val = 1'b0;
    clear_model();
    repeat (2) @(negedge clk_125);
    rstn = 1'b1;
    @(negedge clk_125);
  endtask

  task automatic wr(input logic [31:0] d, input bit last);
    wr_en = 1'b1; wr_data = d; wr_last = last;
    tick();
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic grant();
    int n;
    n = 0;
    while (!tx_req && n < 10) begin tick(); n++; end
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rem, wait_cyc;
    bit lst;
    rstn = 1'b1;
    wr_en = 1'b0; wr_data = 32'd0; wr_last = 1'b0; tx_rdy = 1'b0; tx_val = 1'b0;
    clear_model();
    #2 rstn = 1'b0;
    #1;
    chk("rst_ctrl", 64'({pkt_cnt, tx_req, tx_st, tx_end, tx_dwen, busy, full, ovf}), 64'(0));
    chk("rst_data", tx_data, 64'(0));
    do_reset();

    // 3-DW MRd header
    wr(32'hA, 1'b0); wr(32'hB, 1'b0); wr(32'hC, 1'b1);
    chk("t1_pkt", 64'(pkt_cnt), 64'(1));
    tick();
    chk("t1_req", 64'(tx_req), 64'(1));
    grant();
    tx_val = 1'b1;
    chk("t1_b1", tx_data, 64'h0000000A_0000000B);
    chk("t1_st", 64'(tx_st), 64'(1));
    tick();
    chk("t1_b2", tx_data, 64'h0000000C_00000000);
    chk("t1_end", 64'({tx_end, tx_dwen}), 64'(3));
    tick();
    tx_val = 1'b0;
    chk("t1_pkt0", 64'(pkt_cnt), 64'(0));
    chk("t1_busy", 64'(busy), 64'(0));

    // single-DW latency
    wr(32'h55, 1'b1);
    chk("lat_t1", 64'(tx_req), 64'(0));
    tick();
    chk("lat_t2", 64'(tx_req), 64'(1));
    grant();
    tx_val = 1'b1; tick(); tx_val = 1'b0;

    // 4-DW with stalls
    wr(32'h1, 1'b0); wr(32'h2, 1'b0); wr(32'h3, 1'b0); wr(32'h4, 1'b1);
    grant();
    chk("t2_b1", tx_data, 64'h00000001_00000002);
    tick();
    chk("t2_b1_hold", tx_data, 64'h00000001_00000002);
    tx_val = 1'b1; tick(); tx_val = 1'b0;
    chk("t2_b2", tx_data, 64'h00000003_00000004);
    tick();
    chk("t2_b2_hold", tx_data, 64'h00000003_00000004);
    chk("t2_end", 64'({tx_end, tx_dwen}), 64'(2));
    tx_val = 1'b1; tick(); tx_val = 1'b0;

    // back-to-back 5 + 2 DWs
    for (int i = 1; i <= 5; i++) wr(32'h50 + 32'(i), i == 5);
    wr(32'h61, 1'b0); wr(32'h62, 1'b1);
    grant();
    tx_val = 1'b1;
    repeat (3) tick();
    tx_val = 1'b0;
    chk("t3_noidle", 64'(busy), 64'(1));
    chk("t3_req", 64'(tx_req), 64'(1));
    grant();
    chk("t3_st", 64'(tx_st), 64'(1));
    chk("t3_data", tx_data, 64'h00000061_00000062);
    tx_val = 1'b1; tick(); tx_val = 1'b0;

    // write completes B while A's final beat is accepted
    wr(32'h71, 1'b0); wr(32'h72, 1'b1); wr(32'h81, 1'b0);
    grant();
    tx_val = 1'b1; wr_en = 1'b1; wr_data = 32'h82; wr_last = 1'b1;
    tick();
    tx_val = 1'b0; wr_en = 1'b0; wr_last = 1'b0;
    chk("t5_pkt", 64'(pkt_cnt), 64'(1));
    chk("t5_req", 64'(tx_req), 64'(1));
    grant();
    chk("t5_data", tx_data, 64'h00000081_00000082);
    tx_val = 1'b1; tick(); tx_val = 1'b0;

    // overflow with AW=2
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      wr(32'(i), 1'b0);
      if (i == 7) chk("t4_notfull", 64'(full), 64'(0));
    end
    chk("t4_full", 64'(full), 64'(1));
    wr(32'd9, 1'b0);
    chk("t4_hold_noovf", 64'(ovf), 64'(0));
    wr(32'd10, 1'b0);
    chk("t4_ovf", 64'(ovf), 64'(1));
    wr(32'd11, 1'b1);
    tick();
    chk("t4_ovf_sticky", 64'(ovf), 64'(1));

    // reset during SEND
    do_reset();
    wr(32'h91, 1'b0); wr(32'h92, 1'b0); wr(32'h93, 1'b1);
    grant();
    chk("t6_insend", 64'(tx_st), 64'(1));
    rstn = 1'b0;
    #1;
    chk("t6_rst_ctrl", 64'({tx_st, tx_end, tx_dwen, tx_req, busy, pkt_cnt}), 64'(0));
    chk("t6_rst_data", tx_data, 64'(0));
    clear_model();
    @(negedge clk_125);
    rstn = 1'b1;
    repeat (6) tick();
    chk("t6_noresid", 64'({tx_req, busy}), 64'(0));

    // randomized traffic
    do_reset();
    rem = 0;
    wait_cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      wr_en = 1'b0; wr_last = 1'b0; tx_rdy = 1'b0; tx_val = 1'b0;
      if (rem == 0) rem = int'($urandom_range(1, 8));
      if ($urandom_range(0, 9) < 6) begin
        lst = (rem == 1);
        if (!((m_hold || lst) && (m_ent == DEPTH))) begin
          wr_en = 1'b1; wr_data = $urandom; wr_last = lst; rem--;
        end
      end
      if (m_send) tx_val = ($urandom_range(0, 9) < 7);
      else if (tx_req && (m_pkt > 0) && ($urandom_range(0, 1) == 1)) tx_rdy = 1'b1;
      if (!m_send && (m_pkt > 0) && !tx_req) wait_cyc++;
      else wait_cyc = 0;
      if (wait_cyc > 8) begin
        chk("req_timeout", 64'(tx_req), 64'(1));
        wait_cyc = 0;
      end
      tick();
    end
    wr_en = 1'b0; wr_last = 1'b0; tx_rdy = 1'b0; tx_val = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
